// File: rtl/decode_stage_if.sv
// decode_stage_if: IF/ID request, regfile read port, load-hazard and EX bundle.
// master drives the stage's inputs, slave is the decode stage itself.
interface decode_stage_if #(
    parameter int XLEN          = 32,
    parameter int PC_WIDTH      = 32,
    parameter int REG_IDX_WIDTH = 5
);
    logic                     if_valid_i;
    logic                     if_ready_o;
    logic [31:0]              if_instr_i;
    logic [PC_WIDTH-1:0]      if_pc_i;
    logic                     flush_i;
    logic [REG_IDX_WIDTH-1:0] dec_rs1_idx_o;
    logic [REG_IDX_WIDTH-1:0] dec_rs2_idx_o;
    logic                     dec_rs1_en_o;
    logic                     dec_rs2_en_o;
    logic [XLEN-1:0]          dec_rs1_i;
    logic [XLEN-1:0]          dec_rs2_i;
    logic                     ex_load_valid_i;
    logic [REG_IDX_WIDTH-1:0] ex_load_rd_idx_i;
    logic                     ex_valid_o;
    logic                     ex_ready_i;
    logic [PC_WIDTH-1:0]      ex_pc_o;
    logic [REG_IDX_WIDTH-1:0] ex_rd_idx_o;
    logic                     ex_rd_en_o;
    logic [XLEN-1:0]          ex_alu_op1_o;
    logic [XLEN-1:0]          ex_alu_op2_o;
    logic [3:0]               ex_alu_fun_o;
    logic [XLEN-1:0]          ex_imm_o;
    logic                     ex_branch_o;
    logic                     ex_jump_o;
    logic [2:0]               ex_fun3_o;
    logic                     ex_mem_rena_o;
    logic                     ex_mem_wena_o;
    logic [XLEN-1:0]          ex_store_data_o;
    logic                     ex_illegal_o;

    modport master (
        output if_valid_i, if_instr_i, if_pc_i, flush_i,
        output dec_rs1_i, dec_rs2_i,
        output ex_load_valid_i, ex_load_rd_idx_i, ex_ready_i,
        input  if_ready_o, dec_rs1_idx_o, dec_rs2_idx_o,
        input  dec_rs1_en_o, dec_rs2_en_o,
        input  ex_valid_o, ex_pc_o, ex_rd_idx_o, ex_rd_en_o,
        input  ex_alu_op1_o, ex_alu_op2_o, ex_alu_fun_o, ex_imm_o,
        input  ex_branch_o, ex_jump_o, ex_fun3_o,
        input  ex_mem_rena_o, ex_mem_wena_o, ex_store_data_o,
        input  ex_illegal_o
    );

    modport slave (
        input  if_valid_i, if_instr_i, if_pc_i, flush_i,
        input  dec_rs1_i, dec_rs2_i,
        input  ex_load_valid_i, ex_load_rd_idx_i, ex_ready_i,
        output if_ready_o, dec_rs1_idx_o, dec_rs2_idx_o,
        output dec_rs1_en_o, dec_rs2_en_o,
        output ex_valid_o, ex_pc_o, ex_rd_idx_o, ex_rd_en_o,
        output ex_alu_op1_o, ex_alu_op2_o, ex_alu_fun_o, ex_imm_o,
        output ex_branch_o, ex_jump_o, ex_fun3_o,
        output ex_mem_rena_o, ex_mem_wena_o, ex_store_data_o,
        output ex_illegal_o
    );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode with load-use bubble, flush and EX register.
// Define DECODE_ILLEGAL_TRAP_EN to flag illegal encodings instead of NOPing them.
module decode_stage #(
    parameter int XLEN          = 32,
    parameter int PC_WIDTH      = 32,
    parameter int REG_IDX_WIDTH = 5
) (
    input logic           clk,
    input logic           rst,
    decode_stage_if.slave bus
);
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    function automatic logic [3:0] alu_fun(input logic [2:0] f3, input logic alt);
        alu_fun = ALU_ADD;
        case (f3)
            3'b000: alu_fun = alt ? ALU_SUB : ALU_ADD;
            3'b001: alu_fun = ALU_SLL;
            3'b010: alu_fun = ALU_SLT;
            3'b011: alu_fun = ALU_SLTU;
            3'b100: alu_fun = ALU_XOR;
            3'b101: alu_fun = alt ? ALU_SRA : ALU_SRL;
            3'b110: alu_fun = ALU_OR;
            3'b111: alu_fun = ALU_AND;
            default: alu_fun = ALU_ADD;
        endcase
    endfunction

    logic [31:0]              w_ins;
    logic [6:0]               w_opc;
    logic [2:0]               w_f3;
    logic [6:0]               w_f7;
    logic [REG_IDX_WIDTH-1:0] w_rd, w_rs1, w_rs2;
    logic [XLEN-1:0]          w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [XLEN-1:0]          w_pc, w_shamt;
    logic w_is_opi, w_is_op, w_is_br, w_is_jal, w_is_jalr;
    logic w_is_lui, w_is_auipc, w_is_ld, w_is_st;

    assign w_ins   = bus.if_instr_i;
    assign w_opc   = w_ins[6:0];
    assign w_f3    = w_ins[14:12];
    assign w_f7    = w_ins[31:25];
    assign w_rd    = REG_IDX_WIDTH'(w_ins[11:7]);
    assign w_rs1   = REG_IDX_WIDTH'(w_ins[19:15]);
    assign w_rs2   = REG_IDX_WIDTH'(w_ins[24:20]);
    assign w_imm_i = XLEN'($signed(w_ins[31:20]));
    assign w_imm_s = XLEN'($signed({w_ins[31:25], w_ins[11:7]}));
    assign w_imm_b = XLEN'($signed({w_ins[31], w_ins[7], w_ins[30:25],
                                    w_ins[11:8], 1'b0}));
    assign w_imm_u = XLEN'($signed({w_ins[31:12], 12'b0}));
    assign w_imm_j = XLEN'($signed({w_ins[31], w_ins[19:12], w_ins[20],
                                    w_ins[30:21], 1'b0}));
    assign w_pc    = XLEN'(bus.if_pc_i);
    assign w_shamt = XLEN'(w_ins[24:20]);

    assign w_is_opi   = (w_opc == 7'h13);
    assign w_is_op    = (w_opc == 7'h33);
    assign w_is_br    = (w_opc == 7'h63);
    assign w_is_jal   = (w_opc == 7'h6F);
    assign w_is_jalr  = (w_opc == 7'h67);
    assign w_is_lui   = (w_opc == 7'h37);
    assign w_is_auipc = (w_opc == 7'h17);
    assign w_is_ld    = (w_opc == 7'h03);
    assign w_is_st    = (w_opc == 7'h23);

    logic            w_rs1_en, w_rs2_en, w_rd_wr, w_rd_en;
    logic [3:0]      w_fun;
    logic [XLEN-1:0] w_op1, w_op2, w_imm, w_sdata;
    logic            w_branch, w_jump, w_rena, w_wena, w_bad, w_illegal;

    always_comb begin
        w_rs1_en = 1'b0;
        w_rs2_en = 1'b0;
        w_rd_wr  = 1'b0;
        w_fun    = ALU_ADD;
        w_op1    = '0;
        w_op2    = '0;
        w_imm    = '0;
        w_sdata  = '0;
        w_branch = 1'b0;
        w_jump   = 1'b0;
        w_rena   = 1'b0;
        w_wena   = 1'b0;
        w_bad    = 1'b0;
        unique case (1'b1)
            w_is_opi: begin
                w_rs1_en = 1'b1;
                w_rd_wr  = 1'b1;
                w_op1    = bus.dec_rs1_i;
                w_imm    = w_imm_i;
                w_fun    = alu_fun(w_f3, w_f3[2] & w_ins[30]);
                w_op2    = (w_f3[1:0] == 2'b01) ? w_shamt : w_imm_i;
            end
            w_is_op: begin
                w_rs1_en = 1'b1;
                w_rs2_en = 1'b1;
                w_rd_wr  = 1'b1;
                w_op1    = bus.dec_rs1_i;
                w_op2    = bus.dec_rs2_i;
                w_fun    = alu_fun(w_f3, w_f7[5]);
                w_bad    = (w_f7 != 7'h00) && (w_f7 != 7'h20);
            end
            w_is_br: begin
                w_rs1_en = 1'b1;
                w_rs2_en = 1'b1;
                w_op1    = bus.dec_rs1_i;
                w_op2    = bus.dec_rs2_i;
                w_imm    = w_imm_b;
                w_branch = 1'b1;
                unique case (w_f3[2:1])
                    2'b00: w_fun = ALU_XOR;
                    2'b01: w_bad = 1'b1;
                    2'b10: w_fun = ALU_SLT;
                    2'b11: w_fun = ALU_SLTU;
                    default: w_bad = 1'b1;
                endcase
            end
            w_is_jal, w_is_jalr: begin
                w_rs1_en = w_is_jalr;
                w_rd_wr  = 1'b1;
                w_jump   = 1'b1;
                w_op1    = w_pc;
                w_op2    = XLEN'(3'd4);
                w_imm    = w_is_jal ? w_imm_j : w_imm_i;
            end
            w_is_lui, w_is_auipc: begin
                w_rd_wr = 1'b1;
                w_op1   = w_is_auipc ? w_pc : '0;
                w_op2   = w_imm_u;
                w_imm   = w_imm_u;
            end
            w_is_ld: begin
                w_rs1_en = 1'b1;
                w_rd_wr  = 1'b1;
                w_rena   = 1'b1;
                w_op1    = bus.dec_rs1_i;
                w_op2    = w_imm_i;
                w_imm    = w_imm_i;
                w_bad    = (w_f3 == 3'b011) || (w_f3[2:1] == 2'b11);
            end
            w_is_st: begin
                w_rs1_en = 1'b1;
                w_rs2_en = 1'b1;
                w_wena   = 1'b1;
                w_op1    = bus.dec_rs1_i;
                w_op2    = w_imm_s;
                w_imm    = w_imm_s;
                w_sdata  = bus.dec_rs2_i;
                w_bad    = w_f3[2] | (w_f3[1] & w_f3[0]);
            end
            default: w_bad = 1'b1;
        endcase
        if (w_bad) begin
`ifdef DECODE_ILLEGAL_TRAP_EN
            w_rd_wr = 1'b0;
            w_rena  = 1'b0;
            w_wena  = 1'b0;
`else
            w_rs1_en = 1'b0;
            w_rs2_en = 1'b0;
            w_rd_wr  = 1'b0;
            w_fun    = ALU_ADD;
            w_op1    = '0;
            w_op2    = '0;
            w_imm    = '0;
            w_sdata  = '0;
            w_branch = 1'b0;
            w_jump   = 1'b0;
            w_rena   = 1'b0;
            w_wena   = 1'b0;
`endif
        end
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    assign w_illegal = w_bad;
`else
    assign w_illegal = 1'b0;
`endif

    assign w_rd_en = w_rd_wr & (w_rd != '0);

    logic w_stall, w_ready, w_xfer;
    logic r_valid;

    // A load in EX whose rd feeds this instruction cannot be forwarded yet.
    assign w_stall = bus.ex_load_valid_i && (bus.ex_load_rd_idx_i != '0) &&
                     ((w_rs1_en && (w_rs1 == bus.ex_load_rd_idx_i)) ||
                      (w_rs2_en && (w_rs2 == bus.ex_load_rd_idx_i)));
    assign w_ready = ~w_stall & (~r_valid | bus.ex_ready_i);
    assign w_xfer  = bus.if_valid_i & w_ready;

    assign bus.if_ready_o    = w_ready;
    assign bus.dec_rs1_idx_o = w_rs1;
    assign bus.dec_rs2_idx_o = w_rs2;
    assign bus.dec_rs1_en_o  = w_rs1_en;
    assign bus.dec_rs2_en_o  = w_rs2_en;

    logic [PC_WIDTH-1:0]      r_pc;
    logic [REG_IDX_WIDTH-1:0] r_rd_idx;
    logic                     r_rd_en, r_branch, r_jump, r_rena, r_wena, r_illegal;
    logic [XLEN-1:0]          r_op1, r_op2, r_imm, r_sdata;
    logic [3:0]               r_fun;
    logic [2:0]               r_fun3;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_rd_idx  <= '0;
            r_rd_en   <= 1'b0;
            r_op1     <= '0;
            r_op2     <= '0;
            r_fun     <= '0;
            r_imm     <= '0;
            r_branch  <= 1'b0;
            r_jump    <= 1'b0;
            r_fun3    <= '0;
            r_rena    <= 1'b0;
            r_wena    <= 1'b0;
            r_sdata   <= '0;
            r_illegal <= 1'b0;
        end else if (bus.flush_i) begin
            r_valid <= 1'b0;
        end else if (w_xfer) begin
            r_valid   <= 1'b1;
            r_pc      <= bus.if_pc_i;
            r_rd_idx  <= w_rd;
            r_rd_en   <= w_rd_en;
            r_op1     <= w_op1;
            r_op2     <= w_op2;
            r_fun     <= w_fun;
            r_imm     <= w_imm;
            r_branch  <= w_branch;
            r_jump    <= w_jump;
            r_fun3    <= w_f3;
            r_rena    <= w_rena;
            r_wena    <= w_wena;
            r_sdata   <= w_sdata;
            r_illegal <= w_illegal;
        end else if (!r_valid || bus.ex_ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.ex_valid_o      = r_valid;
    assign bus.ex_pc_o         = r_pc;
    assign bus.ex_rd_idx_o     = r_rd_idx;
    assign bus.ex_rd_en_o      = r_rd_en;
    assign bus.ex_alu_op1_o    = r_op1;
    assign bus.ex_alu_op2_o    = r_op2;
    assign bus.ex_alu_fun_o    = r_fun;
    assign bus.ex_imm_o        = r_imm;
    assign bus.ex_branch_o     = r_branch;
    assign bus.ex_jump_o       = r_jump;
    assign bus.ex_fun3_o       = r_fun3;
    assign bus.ex_mem_rena_o   = r_rena;
    assign bus.ex_mem_wena_o   = r_wena;
    assign bus.ex_store_data_o = r_sdata;
    assign bus.ex_illegal_o    = r_illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and random stimulus for decode_stage, checked
// against a specification-level decode model and handshake scoreboard.
module tb_decode_stage;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_stage_if bus ();
    decode_stage dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        rd_c;
        logic        rd_en;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  fun;
        logic [31:0] imm;
        logic        imm_c;
        logic        br;
        logic        jmp;
        logic [2:0]  f3;
        logic        rena;
        logic        wena;
        logic [31:0] sd;
        logic        sd_c;
        logic        ill;
        logic        rs1_en;
        logic        rs2_en;
    } exp_t;

    localparam logic [3:0] FTAB [8] = '{4'd0, 4'd2, 4'd3, 4'd4,
                                        4'd5, 4'd6, 4'd8, 4'd9};
    localparam logic [6:0] OPCS [10] = '{7'h13, 7'h33, 7'h63, 7'h6F, 7'h67,
                                         7'h37, 7'h17, 7'h03, 7'h23, 7'h7F};

    int     errs = 0;
    int     checks = 0;
    logic   m_valid;
    exp_t   m;
    logic   rdy_seen;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t ref_dec(input logic [31:0] w, input logic [31:0] pc,
                                     input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int iimm, simm, bimm, jimm;
        logic [2:0] f3;
        logic [6:0] f7;
        logic bad;
        e    = '0;
        f3   = w[14:12];
        f7   = w[31:25];
        bad  = 1'b0;
        iimm = $signed(w) >>> 20;
        simm = ($signed(w) >>> 25) * 32 + int'(w[11:7]);
        bimm = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 +
               int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
        jimm = (w[31] ? -1048576 : 0) + int'(w[19:12]) * 4096 +
               int'(w[20]) * 2048 + int'(w[30:21]) * 2;
        e.pc = pc;
        e.f3 = f3;
        e.rd = w[11:7];
        case (w[6:0])
            7'h13: begin
                e.rs1_en = 1'b1; e.rd_en = 1'b1; e.op1 = a;
                e.fun = FTAB[f3];
                if (f3 == 3'd5 && w[30]) e.fun = 4'd7;
                e.op2 = (f3 == 3'd1 || f3 == 3'd5) ? 32'(w[24:20]) : iimm;
            end
            7'h33: begin
                e.rs1_en = 1'b1; e.rs2_en = 1'b1; e.rd_en = 1'b1;
                e.op1 = a; e.op2 = b; e.fun = FTAB[f3];
                if (f7 == 7'h20 && f3 == 3'd0) e.fun = 4'd1;
                if (f7 == 7'h20 && f3 == 3'd5) e.fun = 4'd7;
                bad = (f7 != 7'h00) && (f7 != 7'h20);
            end
            7'h63: begin
                e.rs1_en = 1'b1; e.rs2_en = 1'b1; e.br = 1'b1;
                e.op1 = a; e.op2 = b; e.imm = bimm;
                if (f3 < 3'd2) e.fun = 4'd5;
                else if (f3 < 3'd4) bad = 1'b1;
                else if (f3 < 3'd6) e.fun = 4'd3;
                else e.fun = 4'd4;
            end
            7'h6F: begin
                e.jmp = 1'b1; e.rd_en = 1'b1; e.op1 = pc; e.op2 = 32'd4;
                e.imm = jimm;
            end
            7'h67: begin
                e.rs1_en = 1'b1; e.jmp = 1'b1; e.rd_en = 1'b1;
                e.op1 = pc; e.op2 = 32'd4; e.imm = iimm;
            end
            7'h37: begin
                e.rd_en = 1'b1; e.op2 = w & 32'hFFFFF000;
            end
            7'h17: begin
                e.rd_en = 1'b1; e.op1 = pc; e.op2 = w & 32'hFFFFF000;
            end
            7'h03: begin
                e.rs1_en = 1'b1; e.rd_en = 1'b1; e.rena = 1'b1;
                e.op1 = a; e.op2 = iimm;
                bad = (f3 == 3'd3) || (f3 >= 3'd6);
            end
            7'h23: begin
                e.rs1_en = 1'b1; e.rs2_en = 1'b1; e.wena = 1'b1;
                e.op1 = a; e.op2 = simm; e.sd = b;
                bad = (f3 >= 3'd3);
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
`ifdef DECODE_ILLEGAL_TRAP_EN
            e.ill = 1'b1; e.rd_en = 1'b0; e.rena = 1'b0; e.wena = 1'b0;
`else
            e = '0; e.pc = pc; e.f3 = f3; e.rd = w[11:7];
`endif
        end
        e.rd_en = e.rd_en && (w[11:7] != 5'd0);
        e.rd_c  = e.rd_en;
        e.imm_c = e.br || e.jmp;
        e.sd_c  = e.wena;
        return e;
    endfunction

    task automatic check_regs();
        check("ex_valid", 64'(bus.ex_valid_o), 64'(m_valid));
        check("ex_pc", 64'(bus.ex_pc_o), 64'(m.pc));
        if (m.rd_c) check("ex_rd_idx", 64'(bus.ex_rd_idx_o), 64'(m.rd));
        check("ex_rd_en", 64'(bus.ex_rd_en_o), 64'(m.rd_en));
        check("ex_op1", 64'(bus.ex_alu_op1_o), 64'(m.op1));
        check("ex_op2", 64'(bus.ex_alu_op2_o), 64'(m.op2));
        check("ex_fun", 64'(bus.ex_alu_fun_o), 64'(m.fun));
        check("ex_branch", 64'(bus.ex_branch_o), 64'(m.br));
        check("ex_jump", 64'(bus.ex_jump_o), 64'(m.jmp));
        check("ex_fun3", 64'(bus.ex_fun3_o), 64'(m.f3));
        check("ex_rena", 64'(bus.ex_mem_rena_o), 64'(m.rena));
        check("ex_wena", 64'(bus.ex_mem_wena_o), 64'(m.wena));
        check("ex_illegal", 64'(bus.ex_illegal_o), 64'(m.ill));
        if (m.imm_c) check("ex_imm", 64'(bus.ex_imm_o), 64'(m.imm));
        if (m.sd_c) check("ex_sdata", 64'(bus.ex_store_data_o), 64'(m.sd));
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m       = '0;
        m.rd_c  = 1'b1;
        m.imm_c = 1'b1;
        m.sd_c  = 1'b1;
    endtask

    task automatic cyc(input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic v, input logic rdy, input logic fl,
                       input logic lv, input logic [4:0] lrd, input logic r);
        exp_t e;
        logic stall, er;
        rst                  = r;
        bus.if_valid_i       = v;
        bus.if_instr_i       = ins;
        bus.if_pc_i          = pc;
        bus.dec_rs1_i        = a;
        bus.dec_rs2_i        = b;
        bus.ex_ready_i       = rdy;
        bus.flush_i          = fl;
        bus.ex_load_valid_i  = lv;
        bus.ex_load_rd_idx_i = lrd;
        #1;
        e     = ref_dec(ins, pc, a, b);
        stall = lv && (lrd != 5'd0) &&
                ((e.rs1_en && ins[19:15] == lrd) ||
                 (e.rs2_en && ins[24:20] == lrd));
        er    = !stall && (!m_valid || rdy);
        rdy_seen = bus.if_ready_o;
        check("if_ready", 64'(bus.if_ready_o), 64'(er));
        check("rs1_idx", 64'(bus.dec_rs1_idx_o), 64'(ins[19:15]));
        check("rs2_idx", 64'(bus.dec_rs2_idx_o), 64'(ins[24:20]));
        check("rs1_en", 64'(bus.dec_rs1_en_o), 64'(e.rs1_en));
        check("rs2_en", 64'(bus.dec_rs2_en_o), 64'(e.rs2_en));
        if (r) model_reset();
        else if (fl) m_valid = 1'b0;
        else if (v && er) begin
            m_valid = 1'b1;
            m       = e;
        end else if (!m_valid || rdy) m_valid = 1'b0;
        @(posedge clk);
        #1;
        check_regs();
    endtask

    logic [31:0] ins;
    logic [4:0]  lrd;

    initial begin
        rst = 1'b1;
        bus.if_valid_i = 1'b0; bus.if_instr_i = '0; bus.if_pc_i = '0;
        bus.dec_rs1_i = '0; bus.dec_rs2_i = '0; bus.ex_ready_i = 1'b0;
        bus.flush_i = 1'b0; bus.ex_load_valid_i = 1'b0;
        bus.ex_load_rd_idx_i = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_regs();

        // ADDI x1,x2,-1
        cyc(32'hFFF10093, 32'h40, 32'd5, 32'd0, 1, 1, 0, 0, 5'd0, 0);
        check("addi_valid", 64'(bus.ex_valid_o), 64'd1);
        check("addi_op1", 64'(bus.ex_alu_op1_o), 64'd5);
        check("addi_op2", 64'(bus.ex_alu_op2_o), 64'hFFFFFFFF);
        check("addi_fun", 64'(bus.ex_alu_fun_o), 64'd0);
        check("addi_rd", 64'(bus.ex_rd_idx_o), 64'd1);
        check("addi_rd_en", 64'(bus.ex_rd_en_o), 64'd1);

        // load-use on x2 then release
        cyc(32'h004101B3, 32'h44, 32'h11, 32'h22, 1, 1, 0, 1, 5'd2, 0);
        check("lu_ready", 64'(rdy_seen), 64'd0);
        check("lu_bubble", 64'(bus.ex_valid_o), 64'd0);
        cyc(32'h004101B3, 32'h44, 32'h11, 32'h22, 1, 1, 0, 0, 5'd0, 0);
        check("lu_ready2", 64'(rdy_seen), 64'd1);
        check("lu_valid", 64'(bus.ex_valid_o), 64'd1);
        check("lu_op1", 64'(bus.ex_alu_op1_o), 64'h11);
        check("lu_op2", 64'(bus.ex_alu_op2_o), 64'h22);
        check("lu_fun", 64'(bus.ex_alu_fun_o), 64'd0);

        // SW x5,8(x6)
        cyc(32'h00532423, 32'h48, 32'h100, 32'hAB, 1, 1, 0, 0, 5'd0, 0);
        check("sw_op1", 64'(bus.ex_alu_op1_o), 64'h100);
        check("sw_op2", 64'(bus.ex_alu_op2_o), 64'd8);
        check("sw_wena", 64'(bus.ex_mem_wena_o), 64'd1);
        check("sw_sdata", 64'(bus.ex_store_data_o), 64'hAB);
        check("sw_rd_en", 64'(bus.ex_rd_en_o), 64'd0);
        check("sw_fun3", 64'(bus.ex_fun3_o), 64'd2);

        // backpressure holds the store, then releases
        repeat (3) begin
            cyc(32'hFFF10093, 32'h4C, 32'd7, 32'd0, 1, 0, 0, 0, 5'd0, 0);
            check("bp_ready", 64'(rdy_seen), 64'd0);
            check("bp_hold_op1", 64'(bus.ex_alu_op1_o), 64'h100);
            check("bp_hold_wena", 64'(bus.ex_mem_wena_o), 64'd1);
        end
        cyc(32'hFFF10093, 32'h4C, 32'd7, 32'd0, 1, 1, 0, 0, 5'd0, 0);
        check("bp_release", 64'(rdy_seen), 64'd1);
        check("bp_load_op1", 64'(bus.ex_alu_op1_o), 64'd7);

        // flush with valid entry and incoming instruction
        cyc(32'h004101B3, 32'h50, 32'd1, 32'd2, 1, 1, 1, 0, 5'd0, 0);
        check("fl_valid", 64'(bus.ex_valid_o), 64'd0);
        check("fl_discard", 64'(bus.ex_alu_op1_o), 64'd7);

        // reset mid-stream
        cyc(32'h004101B3, 32'h54, 32'd3, 32'd4, 1, 1, 0, 0, 5'd0, 0);
        cyc(32'h004101B3, 32'h58, 32'd3, 32'd4, 1, 1, 0, 0, 5'd0, 1);
        check("rst_valid", 64'(bus.ex_valid_o), 64'd0);
        check("rst_op1", 64'(bus.ex_alu_op1_o), 64'd0);
        check("rst_pc", 64'(bus.ex_pc_o), 64'd0);

        // all-ones word: unknown opcode
        cyc(32'hFFFFFFFF, 32'h60, 32'd1, 32'd2, 1, 1, 0, 0, 5'd0, 0);
        check("ill_valid", 64'(bus.ex_valid_o), 64'd1);
        check("ill_rd_en", 64'(bus.ex_rd_en_o), 64'd0);
`ifdef DECODE_ILLEGAL_TRAP_EN
        check("ill_flag", 64'(bus.ex_illegal_o), 64'd1);
`else
        check("ill_flag", 64'(bus.ex_illegal_o), 64'd0);
`endif

        for (int i = 0; i < 3000; i++) begin
            ins = $urandom;
            ins[6:0] = OPCS[$urandom_range(0, 9)];
            if ($urandom_range(0, 1) == 0)
                ins[31:25] = ($urandom_range(0, 1) == 0) ? 7'h20 : 7'h00;
            case ($urandom_range(0, 2))
                0: lrd = ins[19:15];
                1: lrd = ins[24:20];
                default: lrd = 5'($urandom);
            endcase
            cyc(ins, $urandom, $urandom, $urandom,
                $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0,
                lrd, $urandom_range(0, 199) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
